// File: rtl/ksa_sub_serial.sv
`default_nettype none
// ============================================================================
//  Module      : ksa_sub_serial
//  Description : Nibble-serial subtractor, a - b - bin over WIDTH bits, one
//                4-bit digit per clock (LSB first), valid/ready on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module ksa_sub_serial #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int C_N  = WIDTH / 4;
    localparam int C_CW = (C_N > 1) ? $clog2(C_N) : 1;
    localparam logic [C_CW-1:0] C_LAST = C_CW'(C_N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_diff;
    logic              r_carry;
    logic [C_CW-1:0]   r_cnt;

    logic              w_accept;
    logic              w_last;
    logic [C_CW+1:0]   w_shift;
    logic [WIDTH-1:0]  w_a_sh;
    logic [WIDTH-1:0]  w_b_sh;
    logic [3:0]        w_a_nib;
    logic [3:0]        w_b_nib;
    logic [4:0]        w_sum;

    // Current digit: bit offset is 4*k, and the slice adds a + ~b + carry.
    assign w_shift  = {r_cnt, 2'b00};
    assign w_a_sh   = r_a >> w_shift;
    assign w_b_sh   = r_b >> w_shift;
    assign w_a_nib  = w_a_sh[3:0];
    assign w_b_nib  = w_b_sh[3:0];
    assign w_sum    = {1'b0, w_a_nib} + {1'b0, ~w_b_nib} + {4'b0000, r_carry};
    assign w_last   = (r_cnt == C_LAST);
    assign w_accept = in_valid & in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and handshake outputs (state-only decode)
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture and digit-serial datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_diff  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_diff  <= '0;
            r_carry <= ~bin;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            // diff was cleared on accept, so OR-ing the new digit in is exact
            r_diff  <= r_diff | (WIDTH'(w_sum[3:0]) << w_shift);
            r_carry <= w_sum[4];
            if (!w_last) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Result and flags; flags are qualified so they read 0 outside DONE
    assign diff = r_diff;
    assign bout = out_valid & ~r_carry;
    assign ovf  = out_valid & (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (r_diff[WIDTH-1] ^ r_a[WIDTH-1]);
    assign zero = out_valid & (r_diff == '0);

endmodule
`default_nettype wire

// File: tb/tb_ksa_sub_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ksa_sub_serial
//  Description : Self-checking bench for ksa_sub_serial at WIDTH 16, 4, 32.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ksa_sub_serial;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a_drv = '0;
    logic [31:0] b_drv = '0;
    logic        bin_drv = 1'b0;
    logic [2:0]  iv = '0;
    logic [2:0]  ordy = '0;

    logic        rdy16, val16, bo16, of16, z16;
    logic        rdy4,  val4,  bo4,  of4,  z4;
    logic        rdy32, val32, bo32, of32, z32;
    logic [15:0] diff16;
    logic [3:0]  diff4;
    logic [31:0] diff32;

    int          sel = 0;
    logic        m_rdy, m_val, m_bout, m_ovf, m_zero;
    logic [31:0] m_diff;

    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ksa_sub_serial #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy16),
        .a(a_drv[15:0]), .b(b_drv[15:0]), .bin(bin_drv),
        .out_valid(val16), .out_ready(ordy[0]), .diff(diff16),
        .bout(bo16), .ovf(of16), .zero(z16)
    );

    ksa_sub_serial #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy4),
        .a(a_drv[3:0]), .b(b_drv[3:0]), .bin(bin_drv),
        .out_valid(val4), .out_ready(ordy[1]), .diff(diff4),
        .bout(bo4), .ovf(of4), .zero(z4)
    );

    ksa_sub_serial #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(rdy32),
        .a(a_drv), .b(b_drv), .bin(bin_drv),
        .out_valid(val32), .out_ready(ordy[2]), .diff(diff32),
        .bout(bo32), .ovf(of32), .zero(z32)
    );

    // Route the selected instance onto common observation signals
    always_comb begin
        m_rdy = rdy32; m_val = val32; m_diff = diff32;
        m_bout = bo32; m_ovf = of32; m_zero = z32;
        case (sel)
            0: begin
                m_rdy = rdy16; m_val = val16; m_diff = {16'd0, diff16};
                m_bout = bo16; m_ovf = of16; m_zero = z16;
            end
            1: begin
                m_rdy = rdy4; m_val = val4; m_diff = {28'd0, diff4};
                m_bout = bo4; m_ovf = of4; m_zero = z4;
            end
            default: ;
        endcase
    end

    function automatic int width_of(input int s);
        return (s == 0) ? 16 : (s == 1) ? 4 : 32;
    endfunction

    // Reference: true unsigned and signed integer subtraction
    function automatic void model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                  input logic bi, output logic [31:0] d, output logic bo,
                                  output logic ov, output logic z);
        longint m  = longint'(1) << w;
        longint ua = longint'(av) & (m - 1);
        longint ub = longint'(bv) & (m - 1);
        longint bl = bi ? 1 : 0;
        longint sa = (ua >= m / 2) ? ua - m : ua;
        longint sb = (ub >= m / 2) ? ub - m : ub;
        longint r  = sa - sb - bl;
        bo = (ua < ub + bl);
        d  = 32'((ua - ub - bl) & (m - 1));
        ov = (r < -(m / 2)) || (r > (m / 2) - 1);
        z  = (d == 32'd0);
    endfunction

    // One full transaction: accept, latency, optional DONE stall, release
    task automatic run_op(input int s, input logic [31:0] av, input logic [31:0] bv,
                          input logic bi, input int stall, output logic [31:0] od,
                          output logic obo, output logic oov, output logic oz);
        int w;
        int cyc;
        sel = s;
        w   = width_of(s);
        @(negedge clk);
        checks++;
        if (m_rdy !== 1'b1 || m_val !== 1'b0)
            begin errors++; $display("FAIL idle_ready w=%0d: in_ready=%b out_valid=%b, want 1/0", w, m_rdy, m_val); end
        a_drv = av; b_drv = bv; bin_drv = bi; iv[s] = 1'b1; ordy[s] = 1'b0;
        @(negedge clk);
        iv[s] = 1'b0;
        a_drv = $urandom; b_drv = $urandom; bin_drv = 1'($urandom);
        checks++;
        if (m_rdy !== 1'b0 || m_val !== 1'b0)
            begin errors++; $display("FAIL run_entry w=%0d: in_ready=%b out_valid=%b, want 0/0", w, m_rdy, m_val); end
        cyc = 0;
        while (m_val !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != w / 4)
            begin errors++; $display("FAIL latency w=%0d: %0d cycles, want %0d", w, cyc, w / 4); end
        od = m_diff; obo = m_bout; oov = m_ovf; oz = m_zero;
        for (int i = 0; i < stall; i++) begin
            iv[s] = 1'b1;
            a_drv = $urandom; b_drv = $urandom; bin_drv = 1'($urandom);
            @(negedge clk);
            checks++;
            if (m_diff !== od || m_bout !== obo || m_ovf !== oov || m_zero !== oz ||
                m_rdy !== 1'b0 || m_val !== 1'b1)
                begin errors++; $display("FAIL stall_hold w=%0d: diff=%h b/o/z=%b%b%b rdy=%b val=%b, want diff=%h b/o/z=%b%b%b rdy=0 val=1",
                                         w, m_diff, m_bout, m_ovf, m_zero, m_rdy, m_val, od, obo, oov, oz); end
        end
        iv[s] = 1'b0;
        ordy[s] = 1'b1;
        @(negedge clk);
        ordy[s] = 1'b0;
        checks++;
        if (m_val !== 1'b0 || m_rdy !== 1'b1 || m_bout !== 1'b0 || m_ovf !== 1'b0 || m_zero !== 1'b0)
            begin errors++; $display("FAIL release w=%0d: val=%b rdy=%b b/o/z=%b%b%b, want 0 1 000",
                                     w, m_val, m_rdy, m_bout, m_ovf, m_zero); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checks++;
            if (m_rdy !== 1'b1 || m_val !== 1'b0 || m_diff !== 32'd0 ||
                m_bout !== 1'b0 || m_ovf !== 1'b0 || m_zero !== 1'b0)
                begin errors++; $display("FAIL reset w=%0d: rdy=%b val=%b diff=%h b/o/z=%b%b%b, want 1 0 0 000",
                                         width_of(s), m_rdy, m_val, m_diff, m_bout, m_ovf, m_zero); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] va [5] = '{32'h1234, 32'h0000, 32'h8000, 32'h0006, 32'h0005};
        logic [31:0] vb [5] = '{32'h0034, 32'h0001, 32'h0001, 32'h0005, 32'h0005};
        logic        vi [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] ed [5] = '{32'h1200, 32'hFFFF, 32'h7FFF, 32'h0000, 32'hFFFF};
        logic [2:0]  ef [5] = '{3'b000, 3'b100, 3'b010, 3'b001, 3'b100};
        logic [31:0] d;
        logic bo, ov, z;
        for (int i = 0; i < 5; i++) begin
            run_op(0, va[i], vb[i], vi[i], 0, d, bo, ov, z);
            checks++;
            if (d !== ed[i] || {bo, ov, z} !== ef[i])
                begin errors++; $display("FAIL directed_%0d: diff=%h b/o/z=%b%b%b, want diff=%h b/o/z=%b",
                                         i, d, bo, ov, z, ed[i], ef[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        logic bo, ov, z;
        run_op(0, 32'hABCD, 32'h1234, 1'b0, 10, d, bo, ov, z);
        checks++;
        if (d !== 32'h9999 || {bo, ov, z} !== 3'b000)
            begin errors++; $display("FAIL backpressure: diff=%h b/o/z=%b%b%b, want diff=9999 b/o/z=000", d, bo, ov, z); end
    endtask

    task automatic test_reset_run();
        logic [31:0] d;
        logic bo, ov, z;
        sel = 0;
        @(negedge clk);
        a_drv = 32'h5555; b_drv = 32'h1111; bin_drv = 1'b0; iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (m_val !== 1'b0 || m_diff !== 32'd0 || m_rdy !== 1'b1 || m_bout !== 1'b0)
            begin errors++; $display("FAIL reset_in_run: val=%b diff=%h rdy=%b bout=%b, want 0 0 1 0", m_val, m_diff, m_rdy, m_bout); end
        run_op(0, 32'hFFFF, 32'h0001, 1'b0, 0, d, bo, ov, z);
        checks++;
        if (d !== 32'hFFFE || {bo, ov, z} !== 3'b000)
            begin errors++; $display("FAIL after_reset: diff=%h b/o/z=%b%b%b, want diff=fffe b/o/z=000", d, bo, ov, z); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] av, bv, d, ed;
        logic bi, bo, ov, z, ebo, eov, ez;
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 200; i++) begin
                av = $urandom;
                bv = $urandom;
                bi = 1'($urandom);
                if (i % 16 == 0) bv = av;
                model(width_of(s), av, bv, bi, ed, ebo, eov, ez);
                run_op(s, av, bv, bi, $urandom_range(0, 3), d, bo, ov, z);
                checks++;
                if (d !== ed || bo !== ebo || ov !== eov || z !== ez)
                    begin errors++; $display("FAIL random w=%0d a=%h b=%h bin=%b: diff=%h b/o/z=%b%b%b, want diff=%h b/o/z=%b%b%b",
                                             width_of(s), av, bv, bi, d, bo, ov, z, ed, ebo, eov, ez); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
